// File: rtl/mem_store_proc.sv
// Store-side lane alignment plus an in-order store buffer draining to memory over req/ack.
// Define MEM_STORE_ALIGN_EXC_EN to trap misaligned SH/SW as address errors instead of enqueuing them.
module mem_store_proc #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_reg_data,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  output logic        o_exc_ade,
  output logic [31:0] o_exc_badvaddr,
  output logic        o_empty
);

  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] depth_c = DEPTH[aw:0];

  localparam logic [5:0] op_sb  = 6'h28;
  localparam logic [5:0] op_sh  = 6'h29;
  localparam logic [5:0] op_swl = 6'h2a;
  localparam logic [5:0] op_sw  = 6'h2b;
  localparam logic [5:0] op_swr = 6'h2e;

  logic [aw:0]   count;
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic        is_store, fault, accept, push, pop;
  logic [1:0]  off, inv;
  logic [31:0] wdata_c;
  logic [3:0]  be_c;

  assign off        = i_addr[1:0];
  assign inv        = ~off;
  assign o_st_ready = !i_rst && (count < depth_c);
  assign accept     = i_st_valid && o_st_ready;
  assign o_mem_req  = (count != '0);
  assign o_empty    = (count == '0);
  assign pop        = o_mem_req && i_mem_ack;
  assign push       = accept && is_store && !fault;

  // Big-endian lanes: offset 0 is bits [31:24] and be[3].
  always_comb begin
    wdata_c  = '0;
    be_c     = '0;
    is_store = 1'b1;
    case (i_instr_op)
      op_sb: begin
        be_c    = 4'b1000 >> off;
        wdata_c = {24'h0, i_reg_data[7:0]} << {inv, 3'b000};
      end
      op_sh: begin
        if (off[1]) begin
          be_c    = 4'b0011;
          wdata_c = {16'h0, i_reg_data[15:0]};
        end else begin
          be_c    = 4'b1100;
          wdata_c = {i_reg_data[15:0], 16'h0};
        end
      end
      op_sw: begin
        be_c    = 4'b1111;
        wdata_c = i_reg_data;
      end
      op_swl: begin
        be_c    = 4'b1111 >> off;
        wdata_c = i_reg_data >> {off, 3'b000};
      end
      op_swr: begin
        be_c    = 4'b1111 << inv;
        wdata_c = i_reg_data << {inv, 3'b000};
      end
      default: is_store = 1'b0;
    endcase
  end

`ifdef MEM_STORE_ALIGN_EXC_EN
  assign fault = accept &&
                 (((i_instr_op == op_sh) && i_addr[0]) ||
                  ((i_instr_op == op_sw) && (off != 2'b00)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_exc_ade      <= 1'b0;
      o_exc_badvaddr <= '0;
    end else begin
      o_exc_ade <= fault;
      if (fault) o_exc_badvaddr <= i_addr;
    end
  end
`else
  assign fault          = 1'b0;
  assign o_exc_ade      = 1'b0;
  assign o_exc_badvaddr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   count <= count + (aw+1)'(1);
        2'b01:   count <= count - (aw+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the outputs are masked while the buffer is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[wr_ptr] <= {i_addr[31:2], 2'b00};
      data_q[wr_ptr] <= wdata_c;
      be_q[wr_ptr]   <= be_c;
    end
  end

  assign o_mem_addr  = o_mem_req ? addr_q[rd_ptr] : '0;
  assign o_mem_wdata = o_mem_req ? data_q[rd_ptr] : '0;
  assign o_mem_be    = o_mem_req ? be_q[rd_ptr]   : '0;

endmodule

// File: tb/tb_mem_store_proc.sv
// Self-checking bench for mem_store_proc: scoreboard of expected memory writes, popped on each req/ack.
// Honours MEM_STORE_ALIGN_EXC_EN to pick the expected misaligned-store behaviour.
module tb_mem_store_proc;

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWR = 6'h2e;
  localparam logic [5:0] OP_LW  = 6'h23;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_st_valid = 1'b0;
  logic        o_st_ready;
  logic [5:0]  i_instr_op = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_reg_data = '0;
  logic        o_mem_req;
  logic        i_mem_ack = 1'b0;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        o_exc_ade;
  logic [31:0] o_exc_badvaddr;
  logic        o_empty;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  mem_store_proc #(.DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
    .i_instr_op(i_instr_op), .i_addr(i_addr), .i_reg_data(i_reg_data),
    .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .o_exc_ade(o_exc_ade),
    .o_exc_badvaddr(o_exc_badvaddr), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: lane i (0 = MSB) receives register byte k (0 = MSB).
  function automatic void model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                                output bit enq, output exp_t e);
    int off;
    int base;
    off = int'(addr[1:0]);
    e.a = {addr[31:2], 2'b00};
    e.w = '0;
    e.b = '0;
    enq = 1'b1;
    case (op)
      OP_SB: begin
        e.w[31-8*off -: 8] = data[7:0];
        e.b[3-off] = 1'b1;
      end
      OP_SH: begin
        base = off & 2;
        for (int i = 0; i < 2; i++) begin
          e.w[31-8*(base+i) -: 8] = data[31-8*(2+i) -: 8];
          e.b[3-(base+i)] = 1'b1;
        end
`ifdef MEM_STORE_ALIGN_EXC_EN
        if (addr[0]) enq = 1'b0;
`endif
      end
      OP_SW: begin
        e.w = data;
        e.b = 4'b1111;
`ifdef MEM_STORE_ALIGN_EXC_EN
        if (off != 0) enq = 1'b0;
`endif
      end
      OP_SWL: begin
        for (int i = off; i < 4; i++) begin
          e.w[31-8*i -: 8] = data[31-8*(i-off) -: 8];
          e.b[3-i] = 1'b1;
        end
      end
      OP_SWR: begin
        for (int i = 0; i <= off; i++) begin
          e.w[31-8*i -: 8] = data[31-8*(3-off+i) -: 8];
          e.b[3-i] = 1'b1;
        end
      end
      default: enq = 1'b0;
    endcase
  endfunction

  // Scoreboard: the head is committed at the next rising edge whenever req && ack.
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_req && i_mem_ack) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got addr=%h wdata=%h be=%b exp no pending store", o_mem_addr, o_mem_wdata, o_mem_be);
      end else begin
        e = sb.pop_front();
        if (o_mem_addr !== e.a || o_mem_wdata !== e.w || o_mem_be !== e.b) begin
          failures++;
          $display("FAIL sb_write got addr=%h wdata=%h be=%b exp addr=%h wdata=%h be=%b",
                   o_mem_addr, o_mem_wdata, o_mem_be, e.a, e.w, e.b);
        end
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data, output bit enq);
    exp_t e;
    int waited;
    waited = 0;
    i_instr_op = op;
    i_addr = addr;
    i_reg_data = data;
    i_st_valid = 1'b1;
    model(op, addr, data, enq, e);
    while (!o_st_ready && waited < 20) begin
      tick;
      waited++;
    end
    if (!o_st_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got ready=%b exp ready=1 within 20 cycles", o_st_ready);
      i_st_valid = 1'b0;
      enq = 1'b0;
      return;
    end
    if (enq) sb.push_back(e);
    tick;
    i_st_valid = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) tick;
    checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", o_mem_req); end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    checks++; if (o_st_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_st_ready); end
    checks++; if ({o_mem_addr, o_mem_wdata, o_mem_be} !== 68'h0) begin failures++; $display("FAIL reset_outputs got addr=%h wdata=%h be=%b exp 0", o_mem_addr, o_mem_wdata, o_mem_be); end
    checks++; if (o_exc_ade !== 1'b0 || o_exc_badvaddr !== 32'h0) begin failures++; $display("FAIL reset_exc got ade=%b badv=%h exp 0", o_exc_ade, o_exc_badvaddr); end
    i_rst = 1'b0;
    tick;
    checks++; if (o_st_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", o_st_ready); end
  endtask

  task automatic test_sb_lanes;
    bit enq;
    send_store(OP_SB, 32'h0000_1001, 32'h1122_3344, enq);
    checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%b exp=1", o_mem_req); end
    checks++; if (o_mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL sb_addr got=%h exp=00001000", o_mem_addr); end
    checks++; if (o_mem_be !== 4'b0100) begin failures++; $display("FAIL sb_be got=%b exp=0100", o_mem_be); end
    checks++; if (o_mem_wdata !== 32'h0044_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=00440000", o_mem_wdata); end
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    checks++; if (o_mem_req !== 1'b0 || o_empty !== 1'b1) begin failures++; $display("FAIL sb_drain got req=%b empty=%b exp req=0 empty=1", o_mem_req, o_empty); end
  endtask

  task automatic test_swl_swr;
    bit enq;
    send_store(OP_SWL, 32'h0000_2002, 32'hAABB_CCDD, enq);
    checks++; if (o_mem_be !== 4'b0011 || o_mem_wdata !== 32'h0000_AABB) begin failures++; $display("FAIL swl_lanes got be=%b wdata=%h exp be=0011 wdata=0000aabb", o_mem_be, o_mem_wdata); end
    send_store(OP_SWR, 32'h0000_2005, 32'hAABB_CCDD, enq);
    checks++; if (o_mem_addr !== 32'h0000_2000 || o_mem_be !== 4'b0011) begin failures++; $display("FAIL swl_head_stable got addr=%h be=%b exp addr=00002000 be=0011", o_mem_addr, o_mem_be); end
    i_mem_ack = 1'b1;
    tick;
    checks++; if (o_mem_addr !== 32'h0000_2004 || o_mem_be !== 4'b1100 || o_mem_wdata !== 32'hCCDD_0000) begin failures++; $display("FAIL swr_lanes got addr=%h be=%b wdata=%h exp addr=00002004 be=1100 wdata=ccdd0000", o_mem_addr, o_mem_be, o_mem_wdata); end
    tick;
    i_mem_ack = 1'b0;
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL swlswr_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_backpressure;
    bit enq;
    exp_t e;
    send_store(OP_SW, 32'h0000_0010, 32'h0000_0001, enq);
    send_store(OP_SW, 32'h0000_0014, 32'h0000_0002, enq);
    checks++; if (o_st_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", o_st_ready); end
    i_instr_op = OP_SW; i_addr = 32'h0000_0018; i_reg_data = 32'h0000_0003; i_st_valid = 1'b1;
    model(OP_SW, 32'h0000_0018, 32'h0000_0003, enq, e);
    sb.push_back(e);
    tick;
    checks++; if (o_st_ready !== 1'b0 || o_mem_addr !== 32'h0000_0010) begin failures++; $display("FAIL bp_held got ready=%b addr=%h exp ready=0 addr=00000010", o_st_ready, o_mem_addr); end
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    checks++; if (o_mem_addr !== 32'h0000_0014 || o_mem_wdata !== 32'h2) begin failures++; $display("FAIL bp_head_advance got addr=%h wdata=%h exp addr=00000014 wdata=00000002", o_mem_addr, o_mem_wdata); end
    checks++; if (o_st_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b exp=1", o_st_ready); end
    tick;
    i_st_valid = 1'b0;
    checks++; if (o_st_ready !== 1'b0) begin failures++; $display("FAIL bp_third_accepted got ready=%b exp=0", o_st_ready); end
    i_mem_ack = 1'b1;
    repeat (2) tick;
    i_mem_ack = 1'b0;
    checks++; if (o_empty !== 1'b1 || sb.size() != 0) begin failures++; $display("FAIL bp_drain got empty=%b pending=%0d exp empty=1 pending=0", o_empty, sb.size()); end
  endtask

  task automatic test_simul_push_pop;
    bit enq;
    exp_t e;
    send_store(OP_SW, 32'h0000_0040, 32'hDEAD_BEEF, enq);
    i_instr_op = OP_SH; i_addr = 32'h0000_0042; i_reg_data = 32'h1234_ABCD; i_st_valid = 1'b1;
    model(OP_SH, 32'h0000_0042, 32'h1234_ABCD, enq, e);
    sb.push_back(e);
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    i_st_valid = 1'b0;
    checks++; if (o_mem_req !== 1'b1 || o_st_ready !== 1'b1) begin failures++; $display("FAIL pp_count_one got req=%b ready=%b exp req=1 ready=1", o_mem_req, o_st_ready); end
    checks++; if (o_mem_addr !== 32'h0000_0040 || o_mem_be !== 4'b0011 || o_mem_wdata !== 32'h0000_ABCD) begin failures++; $display("FAIL pp_head got addr=%h be=%b wdata=%h exp addr=00000040 be=0011 wdata=0000abcd", o_mem_addr, o_mem_be, o_mem_wdata); end
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL pp_drain got empty=%b exp=1", o_empty); end
  endtask

  task automatic test_back_to_back;
    bit enq;
    logic [5:0] ops [5];
    ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW; ops[3] = OP_SWL; ops[4] = OP_SWR;
    i_mem_ack = 1'b1;
    for (int n = 0; n < 10; n++) begin
      send_store(ops[$urandom_range(0, 4)], $urandom, $urandom, enq);
      checks++; if (o_st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready iter=%0d got=%b exp=1", n, o_st_ready); end
      if (enq) begin
        checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL b2b_req iter=%0d got=%b exp=1", n, o_mem_req); end
      end
    end
    tick;
    i_mem_ack = 1'b0;
    checks++; if (o_empty !== 1'b1 || sb.size() != 0) begin failures++; $display("FAIL b2b_drain got empty=%b pending=%0d exp empty=1 pending=0", o_empty, sb.size()); end
  endtask

  task automatic test_non_store;
    bit enq;
    send_store(OP_LW, 32'h0000_0100, 32'h5555_5555, enq);
    checks++; if (o_mem_req !== 1'b0 || o_empty !== 1'b1) begin failures++; $display("FAIL nonstore got req=%b empty=%b exp req=0 empty=1", o_mem_req, o_empty); end
    checks++; if (o_exc_ade !== 1'b0) begin failures++; $display("FAIL nonstore_exc got=%b exp=0", o_exc_ade); end
  endtask

  task automatic test_misaligned;
    bit enq;
    send_store(OP_SW, 32'h0000_3002, 32'h0000_0055, enq);
`ifdef MEM_STORE_ALIGN_EXC_EN
    checks++; if (o_exc_ade !== 1'b1 || o_exc_badvaddr !== 32'h0000_3002) begin failures++; $display("FAIL mis_exc got ade=%b badv=%h exp ade=1 badv=00003002", o_exc_ade, o_exc_badvaddr); end
    checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL mis_no_req got=%b exp=0", o_mem_req); end
    tick;
    checks++; if (o_exc_ade !== 1'b0 || o_exc_badvaddr !== 32'h0000_3002) begin failures++; $display("FAIL mis_pulse got ade=%b badv=%h exp ade=0 badv=00003002", o_exc_ade, o_exc_badvaddr); end
`else
    checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_3000 || o_mem_be !== 4'b1111 || o_mem_wdata !== 32'h55) begin failures++; $display("FAIL mis_enq got req=%b addr=%h be=%b wdata=%h exp req=1 addr=00003000 be=1111 wdata=00000055", o_mem_req, o_mem_addr, o_mem_be, o_mem_wdata); end
    checks++; if (o_exc_ade !== 1'b0 || o_exc_badvaddr !== 32'h0) begin failures++; $display("FAIL mis_exc_tied got ade=%b badv=%h exp 0", o_exc_ade, o_exc_badvaddr); end
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
`endif
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL mis_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_reset_mid;
    bit enq;
    send_store(OP_SW, 32'h0000_0200, 32'h0000_00AA, enq);
    send_store(OP_SB, 32'h0000_0203, 32'h0000_00BB, enq);
    i_rst = 1'b1;
    tick;
    sb.delete();
    checks++; if (o_mem_req !== 1'b0 || o_empty !== 1'b1 || o_st_ready !== 1'b0) begin failures++; $display("FAIL rstmid got req=%b empty=%b ready=%b exp req=0 empty=1 ready=0", o_mem_req, o_empty, o_st_ready); end
    i_rst = 1'b0;
    tick;
    checks++; if (o_st_ready !== 1'b1 || o_mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_release got ready=%b req=%b exp ready=1 req=0", o_st_ready, o_mem_req); end
  endtask

  initial begin
    test_reset;
    test_sb_lanes;
    test_swl_swr;
    test_backpressure;
    test_simul_push_pop;
    test_back_to_back;
    test_non_store;
    test_misaligned;
    test_reset_mid;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL final_pending got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_store_proc.md
# mem_store_proc

- Store-side counterpart of the load data alignment logic in the memory stage.
- Accepts store instructions (SB, SH, SW, SWL, SWR) from EXE, turns register data into a big-endian word-aligned write (address, data, byte enables), and queues it in a 2-entry in-order buffer.
- Buffer entries drain to data memory over a req/ack handshake, so EXE does not stall on slow memory writes.

## Interface
Parameters:
- DEPTH, 2, store buffer entries; supported values are 2 and 4.

Ports:
- i_clk  in  1  sole clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_st_valid  in  1  store request valid
- o_st_ready  out  1  buffer can accept a request
- i_instr_op  in  6  opcode, `OP_SB/`OP_SH/`OP_SW/`OP_SWL/`OP_SWR from Include/OP.v
- i_addr  in  32  effective byte address
- i_reg_data  in  32  rt register value
- o_mem_req  out  1  head entry valid toward memory
- i_mem_ack  in  1  memory accepted head entry
- o_mem_addr  out  32  {addr[31:2], 2'b00}
- o_mem_wdata  out  32  lane-aligned write data
- o_mem_be  out  4  byte enables; bit 3 = bits [31:24] = byte offset 0
- o_exc_ade  out  1  address-error-on-store pulse
- o_exc_badvaddr  out  32  faulting address
- o_empty  out  1  buffer empty; used by SYNC and load ordering

## Operation
- **Accept.** A request is accepted on a cycle where i_st_valid && o_st_ready.
- **Non-store opcodes.** An accepted non-store opcode is consumed and nothing is enqueued.
- **Lane mapping.** Big-endian; off = i_addr[1:0]. Unlisted bits of o_mem_wdata are 0.
  - SB: be = 4'b1000>>off; byte reg[7:0] placed at lane off.
  - SH: off[1]=0 -> be 1100, wdata {reg[15:0],16'h0}; off[1]=1 -> be 0011, wdata {16'h0,reg[15:0]}.
  - SW: be 1111, wdata reg.
  - SWL: be = 4'b1111>>off; wdata = reg>>(8*off).
  - SWR: be = 4'b1111<<(3-off) truncated to 4 bits; wdata = reg<<(8*(3-off)).
- **Ordering.** The buffer is a FIFO with count 0..DEPTH and strictly in-order drain.
- **Memory handshake.**
  - o_mem_req = (count != 0).
  - Head addr/wdata/be stay stable while req && !ack.
  - req && ack pops the head. Ack may arrive in the same cycle req first rises.
- **Ready.** o_st_ready = !i_rst && (count < DEPTH).
  - It has no combinational dependence on i_mem_ack.
  - A full buffer refuses new input even in a cycle where an ack arrives.
- **Simultaneous push and pop.** Count is unchanged, the head advances, and the new entry goes to the tail.
- **Empty flag.** o_empty = (count == 0).

## Timing
- **Reset values.** Count 0, o_mem_req 0, o_mem_addr/o_mem_wdata 0, o_mem_be 0, o_exc_ade 0, o_exc_badvaddr 0, o_empty 1.
- **o_st_ready after reset.** It is 0 while i_rst is high and 1 the cycle after reset deasserts.
- **Enqueue latency.** An accepted store into an empty buffer raises o_mem_req on the next cycle. There is no bypass.
- **Throughput.** One store per cycle in, one per cycle out when ack is held high.
- **Reset mid-operation.** All entries are discarded and o_mem_req drops at the reset edge. Memory must not complete a write that was still unacked at the reset edge.
- **Exception timing.** o_exc_ade is a one-cycle pulse in the cycle after acceptance. o_exc_badvaddr is updated in that same cycle and holds until the next exception.

## Configuration
- **`MEM_STORE_ALIGN_EXC_EN` defined.**
  - Misaligned requests are flagged: SH with i_addr[0]=1, or SW with i_addr[1:0]!=0.
  - A flagged request is consumed but not enqueued.
  - o_exc_ade pulses and o_exc_badvaddr = i_addr.
  - SB, SWL and SWR never fault.
- **Undefined.**
  - o_exc_ade is tied 0 and o_exc_badvaddr is tied 0.
  - Misaligned SH ignores i_addr[0]; misaligned SW ignores i_addr[1:0]. Both are enqueued normally.

## Test plan
- **Reset.** Assert i_rst 3 cycles -> o_mem_req=0, o_empty=1, o_st_ready=0; one cycle after release, o_st_ready=1.
- **SB lanes.** SB reg=0x11223344, addr 0x1001 -> next cycle req=1, addr 0x1000, be=0100, wdata 0x00440000. Ack clears req and sets o_empty=1.
- **SWL/SWR pair.**
  - SWL reg=0xAABBCCDD, addr 0x2002 -> be 0011, wdata 0x0000AABB.
  - Then SWR same reg, addr 0x2005 -> be 1100, wdata 0xCCDD0000.
  - Both drain in order.
- **Backpressure, DEPTH=2, ack held 0.**
  - Push SW 0x1 @0x10, SW 0x2 @0x14 -> o_st_ready=0 and the third valid is held.
  - Pulse ack -> head becomes 0x14.
  - Ready returns 1 next cycle, and the third store is accepted then.
- **Simultaneous push/pop.** Count=1, ack=1 and a new valid SH in the same cycle -> count stays 1, the SH becomes head, wdata/be are correct.
- **Misaligned SW @0x3002.**
  - With `MEM_STORE_ALIGN_EXC_EN`: exc_ade pulses 1 cycle, badvaddr 0x3002, no o_mem_req.
  - Without it: req with addr 0x3000, be 1111.
